neuron_scheduler: RTL
=====================

NEURON_SCHEDULER -- requirements
Module: neuron_scheduler

Interface
REQ-001 Parameter NUM_NEURONS, default 4: number of attached neuron_core instances (range 2..64).
REQ-002 Parameter ID_WIDTH, default 2: clog2(NUM_NEURONS), width of neuron index.
REQ-003 Parameter FIFO_DEPTH, default 4: spike-event FIFO entries (power of 2).
REQ-004 Parameter TIMEOUT, default 15: max WAIT/RST_WAIT cycles before abort.
REQ-005 clk  in  1  single clock; all state changes on posedge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 timestep_start  in  1  one-cycle pulse requesting an update sweep of all neurons.
REQ-008 reset_all  in  1  one-cycle pulse requesting reset of all neurons.
REQ-009 start_update  out  NUM_NEURONS  one-hot update strobe to neuron cores.
REQ-010 start_reset  out  NUM_NEURONS  reset strobe to neuron cores.
REQ-011 busy_in  in  NUM_NEURONS  per-core busy.
REQ-012 spike_in  in  NUM_NEURONS  per-core spike_detected.
REQ-013 sched_busy  out  1  high in every state except IDLE.
REQ-014 step_done  out  1  one-cycle pulse at sweep completion.
REQ-015 spike_valid / spike_ready / spike_id  out / in / out ID_WIDTH  spike-event stream, valid/ready handshake.
REQ-016 drop_count  out  8  saturating count of spikes lost to FIFO full.
REQ-017 timeout_err, overrun_err  out  1 each  sticky error flags.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, DONE, RST_ISSUE, RST_WAIT.
REQ-019 IDLE: reset_all -> RST_ISSUE; else timestep_start -> ISSUE with index=0; reset_all has priority when both are asserted.
REQ-020 ISSUE lasts one cycle; start_update[index]=1, all other strobe bits 0; next state WAIT, wait counter cleared.
REQ-021 WAIT: when busy_in[index]==0, sample spike_in[index]; if 1, push index into FIFO; then ISSUE with index+1, or DONE if index==NUM_NEURONS-1.
REQ-022 Nominal per-neuron latency SHALL be 3 cycles (ISSUE, WAIT busy=1, WAIT busy=0 capture); step_done asserts in cycle 3*NUM_NEURONS after the first ISSUE cycle.
REQ-023 WAIT counter reaching TIMEOUT with busy still high: set timeout_err, skip neuron (no capture), advance as in REQ-021.
REQ-024 DONE lasts one cycle with step_done=1, then IDLE.
REQ-025 RST_ISSUE: start_reset all ones for one cycle -> RST_WAIT.
REQ-026 RST_WAIT: exit to IDLE when busy_in all zero; TIMEOUT expiry sets timeout_err and exits to IDLE.
REQ-027 timestep_start or reset_all arriving outside IDLE SHALL be ignored and set overrun_err.
REQ-028 FIFO: push on capture when not full; pop when spike_valid && spike_ready; spike_id = head entry; spike_valid = not empty.
REQ-029 Push while full SHALL be accepted only if a pop occurs the same cycle; otherwise the spike is dropped and drop_count increments, saturating at 255.
REQ-030 Push and pop while empty: spike_valid stays 0 that cycle, entry visible next cycle.
REQ-031 FIFO contents are not flushed by reset_all.

Reset
REQ-032 rst: state IDLE, index 0, counters 0, FIFO empty; all outputs 0 (start_update, start_reset, sched_busy, step_done, spike_valid, spike_id, drop_count, timeout_err, overrun_err).
REQ-033 rst mid-sweep SHALL abort immediately; no strobe is issued in the cycle following rst.
REQ-034 Error flags and drop_count are cleared only by rst.

Structure
REQ-035 Shared package neuron_sched_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-036 FIFO SHALL be a sub-module spike_event_fifo (width ID_WIDTH, depth FIFO_DEPTH, full/empty outputs).

Verification
REQ-037 NUM_NEURONS=4 with behavioural cores, spike on neurons 1 and 3, spike_ready=1 -> ids 1 then 3 emitted; step_done in cycle 12 after first ISSUE.
REQ-038 spike_ready=0, all 4 neurons spike in 2 sweeps, FIFO_DEPTH=4 -> 4 entries held, drop_count=4, ids 0,1,2,3 in order after ready rises.
REQ-039 Neuron 2 busy stuck high -> timeout_err=1 after 15 WAIT cycles; neurons 0,1,3 still processed; step_done pulses.
REQ-040 reset_all and timestep_start in the same IDLE cycle -> start_reset=4'b1111 for one cycle, no start_update; back to IDLE.
REQ-041 timestep_start pulsed during WAIT -> overrun_err=1, current sweep unaffected, a single step_done.
REQ-042 rst asserted in WAIT of neuron 1 -> next cycle IDLE, all outputs 0, FIFO empty.

Source files
------------

// File: rtl/neuron_sched_pkg.sv
// Shared definitions for the neuron update scheduler: FSM encoding, default
// parameter constants and small arithmetic helpers.
package neuron_sched_pkg;

    localparam int DEF_NUM_NEURONS = 4;
    localparam int DEF_ID_WIDTH    = 2;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_TIMEOUT     = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_DONE      = 3'd3,
        ST_RST_ISSUE = 3'd4,
        ST_RST_WAIT  = 3'd5
    } sched_state_e;

    // Saturating 8-bit increment used by the drop counter
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/neuron_scheduler_if.sv
// Spike-event stream carrying captured neuron indices with valid/ready handshake.
interface neuron_scheduler_if
    import neuron_sched_pkg::*;
#(
    parameter int ID_WIDTH = DEF_ID_WIDTH
);
    logic                spike_valid;
    logic                spike_ready;
    logic [ID_WIDTH-1:0] spike_id;

    modport master (output spike_valid, output spike_id, input spike_ready);
    modport slave  (input spike_valid, input spike_id, output spike_ready);
endinterface

// File: rtl/spike_event_fifo.sv
// Small synchronous FIFO holding spike neuron indices; a push into a full
// FIFO is accepted only when a pop frees the slot in the same cycle.
module spike_event_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign push_ok_s = push & (~full | pop);
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/neuron_scheduler.sv
// Sequences update and reset strobes across the attached neuron cores,
// captures spikes into an event FIFO and reports timeout/overrun errors.
module neuron_scheduler
    import neuron_sched_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int ID_WIDTH    = DEF_ID_WIDTH,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   timestep_start,
    input  logic                   reset_all,
    output logic [NUM_NEURONS-1:0] start_update,
    output logic [NUM_NEURONS-1:0] start_reset,
    input  logic [NUM_NEURONS-1:0] busy_in,
    input  logic [NUM_NEURONS-1:0] spike_in,
    output logic                   sched_busy,
    output logic                   step_done,
    neuron_scheduler_if.master     spike_if,
    output logic [7:0]             drop_count,
    output logic                   timeout_err,
    output logic                   overrun_err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_NEURONS - 1);
    localparam logic [NUM_NEURONS-1:0] ONE_HOT0 = {{(NUM_NEURONS-1){1'b0}}, 1'b1};

    sched_state_e           state_r, next_state_s;
    logic [ID_WIDTH-1:0]    index_r, next_index_s;
    logic [CNT_W-1:0]       wait_cnt_r, next_wait_cnt_s;
    logic                   capture_s;
    logic                   timeout_set_s;
    logic                   overrun_set_s;
    logic                   advance_s;
    logic [NUM_NEURONS-1:0] next_update_s;
    logic [NUM_NEURONS-1:0] next_reset_s;

    logic [NUM_NEURONS-1:0] start_update_r;
    logic [NUM_NEURONS-1:0] start_reset_r;
    logic                   sched_busy_r;
    logic                   step_done_r;
    logic [7:0]             drop_count_r;
    logic                   timeout_err_r;
    logic                   overrun_err_r;

    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   pop_s;
    logic                   drop_s;
    logic [ID_WIDTH-1:0]    fifo_data_s;

    // Next-state, capture and strobe decode
    always_comb begin
        next_state_s    = state_r;
        next_index_s    = index_r;
        next_wait_cnt_s = wait_cnt_r;
        capture_s       = 1'b0;
        timeout_set_s   = 1'b0;
        advance_s       = 1'b0;
        overrun_set_s   = (state_r != ST_IDLE) & (timestep_start | reset_all);
        case (state_r)
            ST_IDLE: begin
                if (reset_all) begin
                    next_state_s = ST_RST_ISSUE;
                end else if (timestep_start) begin
                    next_state_s = ST_ISSUE;
                    next_index_s = '0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                next_state_s    = ST_WAIT;
                next_wait_cnt_s = '0;
            end
            ST_WAIT: begin
                if (!busy_in[index_r]) begin
                    capture_s = spike_in[index_r];
                    advance_s = 1'b1;
                end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    timeout_set_s = 1'b1;
                    advance_s     = 1'b1;
                end else begin
                    next_wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end
                if (advance_s) begin
                    if (index_r == LAST_ID) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_ISSUE;
                        next_index_s = index_r + ID_WIDTH'(1);
                    end
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            ST_RST_ISSUE: begin
                next_state_s    = ST_RST_WAIT;
                next_wait_cnt_s = '0;
            end
            ST_RST_WAIT: begin
                if (busy_in == '0) begin
                    next_state_s = ST_IDLE;
                end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    timeout_set_s = 1'b1;
                    next_state_s  = ST_IDLE;
                end else begin
                    next_wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase

        // Strobes are registered from the upcoming state so they align with it
        if (next_state_s == ST_ISSUE) begin
            next_update_s = ONE_HOT0 << next_index_s;
        end else begin
            next_update_s = '0;
        end
        if (next_state_s == ST_RST_ISSUE) begin
            next_reset_s = '1;
        end else begin
            next_reset_s = '0;
        end
    end

    // State, counters, registered outputs and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            index_r        <= '0;
            wait_cnt_r     <= '0;
            start_update_r <= '0;
            start_reset_r  <= '0;
            sched_busy_r   <= 1'b0;
            step_done_r    <= 1'b0;
            drop_count_r   <= 8'd0;
            timeout_err_r  <= 1'b0;
            overrun_err_r  <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            index_r        <= next_index_s;
            wait_cnt_r     <= next_wait_cnt_s;
            start_update_r <= next_update_s;
            start_reset_r  <= next_reset_s;
            sched_busy_r   <= (next_state_s != ST_IDLE);
            step_done_r    <= (next_state_s == ST_DONE);
            timeout_err_r  <= timeout_err_r | timeout_set_s;
            overrun_err_r  <= overrun_err_r | overrun_set_s;
            if (drop_s) begin
                drop_count_r <= sat_inc8(drop_count_r);
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    assign pop_s  = ~fifo_empty_s & spike_if.spike_ready;
    assign drop_s = capture_s & fifo_full_s & ~pop_s;

    spike_event_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture_s),
        .push_data (index_r),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign spike_if.spike_valid = ~fifo_empty_s;
    assign spike_if.spike_id    = fifo_data_s;

    assign start_update = start_update_r;
    assign start_reset  = start_reset_r;
    assign sched_busy   = sched_busy_r;
    assign step_done    = step_done_r;
    assign drop_count   = drop_count_r;
    assign timeout_err  = timeout_err_r;
    assign overrun_err  = overrun_err_r;

endmodule
